// File: rtl/buzzer_tone_bus_if.sv
// Request side of the buzzer controller's system bus: address, strobes and write lane enables.
// Data and function-complete are shared tri-state wires and are carried as plain ports.
interface buzzer_tone_bus_if;
   logic [31:0] addr_bus;
   logic        rd_bus;
   logic        wr_bus;
   logic [3:0]  data_mask_bus;

   modport master (output addr_bus, rd_bus, wr_bus, data_mask_bus);
   modport slave  (input  addr_bus, rd_bus, wr_bus, data_mask_bus);
endinterface

// File: rtl/buzzer_tone_bus_interface.sv
// Multi-channel buzzer controller: per channel a manual level mode and a hardware
// square-wave tone generator with optional one-shot burst length, mapped on the system bus.
module buzzer_tone_bus_interface #(
   parameter logic [31:0] START_ADDR = 32'h0,
   parameter int          CHANNELS   = 2,
   parameter int          DIV_WIDTH  = 16,
   parameter int          DUR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   buzzer_tone_bus_if.slave      bus,
   inout  wire  [31:0]           data_bus,
   output wire                   fc_bus,
   output wire  [CHANNELS-1:0]   buzz,
   output wire  [CHANNELS-1:0]   busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_LEVEL, ST_TONE} state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
   localparam logic [DUR_WIDTH-1:0] DUR_ONE = DUR_WIDTH'(1);

   function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  mask);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

   logic [32:0]                w_off33;
   logic                       w_hit;
   logic [2:0]                 w_ch;
   logic [1:0]                 w_reg;
   logic                       w_wr_acc;
   logic                       r_wack;
   logic [31:0]                w_rdata;
   logic [CHANNELS-1:0][31:0]  w_ch_rdata;

   // 33-bit subtraction keeps the window test free of wrap-around at any base address
   assign w_off33  = {1'b0, bus.addr_bus} - {1'b0, START_ADDR};
   assign w_hit    = !w_off33[32] && (w_off33[31:0] < 32'(16 * CHANNELS));
   assign w_ch     = w_off33[6:4];
   assign w_reg    = w_off33[3:2];
   assign w_wr_acc = w_hit && bus.wr_bus && !r_wack;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wack <= 1'b0;
      end else begin
         r_wack <= w_hit && bus.wr_bus;
      end
   end

   always_comb begin
      w_rdata = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (w_ch == 3'(c)) begin
            w_rdata = w_ch_rdata[c];
         end
      end
   end

   assign data_bus = (w_hit && bus.rd_bus) ? w_rdata : 'z;
   assign fc_bus   = w_hit ? (bus.rd_bus || (bus.wr_bus && r_wack)) : 1'bz;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic                 r_en, r_mode, r_oneshot, r_level, r_tone;
      logic [DIV_WIDTH-1:0] r_half, r_cnt;
      logic [DUR_WIDTH-1:0] r_dur;
      logic                 w_sel, w_run, w_entry;
      logic [2:0]           w_ctrl_lo;
      logic [DIV_WIDTH-1:0] w_half_wr;
      logic [DUR_WIDTH-1:0] w_dur_wr;
      logic [31:0]          w_ctrl_img, w_rd;
      state_t               w_state;

      assign w_sel     = w_wr_acc && (w_ch == 3'(c));
      assign w_ctrl_lo = bus.data_mask_bus[0] ? data_bus[2:0] : {r_oneshot, r_mode, r_en};
      assign w_half_wr = DIV_WIDTH'(f_merge(32'(r_half), data_bus, bus.data_mask_bus));
      assign w_dur_wr  = DUR_WIDTH'(f_merge(32'(r_dur), data_bus, bus.data_mask_bus));
      // A CTRL write restarts the tone only when it enables the channel or flips its mode
      assign w_entry   = (w_ctrl_lo[0] && !r_en) || (w_ctrl_lo[1] != r_mode);

      always_comb begin
         w_state = ST_IDLE;
         if (r_en) begin
            w_state = r_mode ? ST_TONE : ST_LEVEL;
         end
      end

      assign w_run      = (w_state == ST_TONE) && (r_half != '0);
      assign busy[c]    = w_run;
      assign buzz[c]    = (w_state == ST_LEVEL) ? r_level : (w_run && r_tone);
      assign w_ctrl_img = {23'd0, w_run, 5'd0, r_oneshot, r_mode, r_en};

      always_comb begin
         w_rd = '0;
         case (w_reg)
            2'd0:    w_rd = w_ctrl_img;
            2'd1:    w_rd = {31'd0, r_level};
            2'd2:    w_rd = 32'(r_half);
            default: w_rd = 32'(r_dur);
         endcase
      end
      assign w_ch_rdata[c] = w_rd;

      // Bus write is applied after the tone update so it overrides it on the same edge
      always_ff @(posedge clk) begin
         if (rst) begin
            r_en      <= 1'b0;
            r_mode    <= 1'b0;
            r_oneshot <= 1'b0;
            r_level   <= 1'b0;
            r_tone    <= 1'b0;
            r_half    <= '0;
            r_cnt     <= '0;
            r_dur     <= '0;
         end else begin
            if (w_run) begin
               if (r_oneshot && (r_dur == '0)) begin
                  r_en   <= 1'b0;
                  r_tone <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_cnt <= r_half - DIV_ONE;
                  if (r_oneshot && (r_dur == DUR_ONE)) begin
                     r_en   <= 1'b0;
                     r_tone <= 1'b0;
                     r_dur  <= '0;
                  end else begin
                     r_tone <= ~r_tone;
                     if (r_oneshot) begin
                        r_dur <= r_dur - DUR_ONE;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt - DIV_ONE;
               end
            end
            if (w_sel) begin
               case (w_reg)
                  2'd0: begin
                     r_en      <= w_ctrl_lo[0];
                     r_mode    <= w_ctrl_lo[1];
                     r_oneshot <= w_ctrl_lo[2];
                     if (w_entry) begin
                        r_cnt  <= r_half - DIV_ONE;
                        r_tone <= 1'b0;
                     end
                  end
                  2'd1: r_level <= bus.data_mask_bus[0] ? data_bus[0] : r_level;
                  2'd2: begin
                     r_half <= w_half_wr;
                     r_cnt  <= w_half_wr - DIV_ONE;
                     r_tone <= 1'b0;
                  end
                  default: r_dur <= w_dur_wr;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_buzzer_tone_bus_interface.sv
// Directed bench for the buzzer tone controller: register map, bus handshake,
// tone timing, one-shot bursts, level mode and reset behaviour.
module tb_buzzer_tone_bus_interface;

   localparam logic [31:0] MISS_ADDR = 32'h0000_1000;

   logic        clk;
   logic        rst;
   wire  [31:0] data_bus;
   wire         fc_bus;
   wire  [1:0]  buzz;
   wire  [1:0]  busy;
   logic [31:0] r_drv;
   logic        r_drv_en;
   int          n_checks;
   int          n_fail;
   int          cyc;
   int          t0;
   logic [31:0] d;
   logic        f;

   buzzer_tone_bus_if bus_if ();

   buzzer_tone_bus_interface #(
      .START_ADDR (32'h0),
      .CHANNELS   (2),
      .DIV_WIDTH  (16),
      .DUR_WIDTH  (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .data_bus (data_bus),
      .fc_bus   (fc_bus),
      .buzz     (buzz),
      .busy     (busy)
   );

   assign data_bus = r_drv_en ? r_drv : 'z;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts at a falling edge, holds the strobe across one rising edge, returns at the next falling edge
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      @(negedge clk);
      bus_if.addr_bus      = addr;
      bus_if.data_mask_bus = mask;
      bus_if.wr_bus        = 1'b1;
      r_drv                = data;
      r_drv_en             = 1'b1;
      #1;
      check_eq("wr_fc_first", {31'd0, fc_bus}, 32'd0);
      @(negedge clk);
      check_eq("wr_fc_ack", {31'd0, fc_bus}, 32'd1);
      bus_if.wr_bus = 1'b0;
      r_drv_en      = 1'b0;
      bus_if.addr_bus = MISS_ADDR;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic fc);
      bus_if.addr_bus = addr;
      bus_if.rd_bus   = 1'b1;
      #1;
      data = data_bus;
      fc   = fc_bus;
      bus_if.rd_bus   = 1'b0;
      bus_if.addr_bus = MISS_ADDR;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      r_drv    = '0;
      r_drv_en = 1'b0;
      bus_if.addr_bus      = MISS_ADDR;
      bus_if.rd_bus        = 1'b0;
      bus_if.wr_bus        = 1'b0;
      bus_if.data_mask_bus = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state and zero-latency reads
      check_eq("rst_buzz", {30'd0, buzz}, 32'd0);
      check_eq("rst_busy", {30'd0, busy}, 32'd0);
      bus_read(32'h0, d, f);
      check_eq("rst_ctrl0", d, 32'h0);
      check_eq("rst_rd_fc", {31'd0, f}, 32'd1);
      bus_read(32'h8, d, f);
      check_eq("rst_half0", d, 32'h0);
      bus_read(32'h20, d, f);
      check_eq("miss_fc", {31'd0, f === 1'b1}, 32'd0);

      // Channel 0 tone, half period 3
      bus_write(32'h8, 32'd3, 4'hF);
      bus_read(32'hB, d, f);
      check_eq("half0_lowbits", d, 32'd3);
      bus_write(32'h0, 32'h3, 4'hF);
      t0 = cyc;
      for (int k = 0; k < 12; k++) begin
         check_eq("t2_buzz0", {31'd0, buzz[0]}, 32'((k / 3) % 2));
         if (k == 0) check_eq("t2_busy0", {31'd0, busy[0]}, 32'd1);
         @(negedge clk);
      end

      // Channel 1 one-shot: half 2, four toggles gives two high pulses
      bus_write(32'h18, 32'd2, 4'hF);
      bus_write(32'h1C, 32'd4, 4'hF);
      bus_write(32'h10, 32'h7, 4'hF);
      for (int k = 0; k < 12; k++) begin
         check_eq("t3_buzz1", {31'd0, buzz[1]}, {31'd0, (k == 2) || (k == 3) || (k == 6) || (k == 7)});
         check_eq("t3_buzz0_free", {31'd0, buzz[0]}, 32'(((cyc - t0) / 3) % 2));
         @(negedge clk);
      end
      bus_read(32'h10, d, f);
      check_eq("t3_ctrl1_en_busy", d & 32'h101, 32'h0);
      check_eq("t3_busy1", {31'd0, busy[1]}, 32'd0);

      // Lane-masked CTRL write sets one-shot with zero duration
      bus_write(32'h0, 32'h0000_00FF, 4'b0001);
      bus_read(32'h0, d, f);
      check_eq("t4_ctrl0_busy", d, 32'h107);
      @(negedge clk);
      bus_read(32'h0, d, f);
      check_eq("t4_ctrl0_os", d, 32'h6);
      check_eq("t4_buzz0_off", {31'd0, buzz[0]}, 32'd0);
      bus_write(32'h4, 32'h1, 4'hF);
      bus_write(32'h0, 32'h1, 4'hF);
      check_eq("t4_level_buzz0", {31'd0, buzz[0]}, 32'd1);
      check_eq("t4_level_busy0", {31'd0, busy[0]}, 32'd0);
      bus_write(32'h0, 32'hFFFF_FFFF, 4'b0000);
      bus_read(32'h0, d, f);
      check_eq("t4_mask0_ctrl0", d, 32'h1);

      // Held write to HALF0 while in tone mode
      bus_write(32'h0, 32'h3, 4'hF);
      @(negedge clk);
      bus_if.addr_bus      = 32'h8;
      bus_if.data_mask_bus = 4'hF;
      bus_if.wr_bus        = 1'b1;
      r_drv                = 32'd2;
      r_drv_en             = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_eq("t5_fc_hold", {31'd0, fc_bus}, {31'd0, k != 0});
         if (k >= 1) check_eq("t5_buzz0", {31'd0, buzz[0]}, {31'd0, k >= 3});
         @(negedge clk);
      end
      bus_if.addr_bus = MISS_ADDR;
      #1;
      check_eq("t5_fc_miss", {31'd0, fc_bus === 1'b1}, 32'd0);
      bus_if.wr_bus = 1'b0;
      r_drv_en      = 1'b0;

      // Reset mid-tone while buzz0 is high
      for (int k = 0; k < 8 && buzz[0] !== 1'b1; k++) @(negedge clk);
      check_eq("t6_pre_high", {31'd0, buzz[0]}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t6_rst_buzz", {30'd0, buzz}, 32'd0);
      check_eq("t6_rst_busy", {30'd0, busy}, 32'd0);
      rst = 1'b0;
      bus_read(32'h8, d, f);
      check_eq("t6_half0_rst", d, 32'h0);

      // Tone mode with zero half period stays silent
      bus_write(32'h0, 32'h3, 4'hF);
      for (int k = 0; k < 4; k++) begin
         check_eq("hp0_buzz0", {31'd0, buzz[0]}, 32'd0);
         check_eq("hp0_busy0", {31'd0, busy[0]}, 32'd0);
         @(negedge clk);
      end

      // DURATION write on the same edge as an internal decrement
      bus_write(32'h18, 32'd1, 4'hF);
      bus_write(32'h1C, 32'd100, 4'hF);
      bus_write(32'h10, 32'h7, 4'hF);
      repeat (3) @(negedge clk);
      bus_write(32'h1C, 32'h55, 4'hF);
      bus_read(32'h1C, d, f);
      check_eq("t6_dur_wins", d, 32'h55);
      @(negedge clk);
      bus_read(32'h1C, d, f);
      check_eq("t6_dur_dec", d, 32'h54);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
